// File: rtl/vector_exec_sequencer_pkg.sv
// Shared types and encodings for the vector instruction sequencer.
// Holds the FSM state enum, SEW/LMUL encodings and register-group sizing.
package vector_exec_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [1:0] SEW_8    = 2'd0;
    localparam logic [1:0] SEW_16   = 2'd1;
    localparam logic [1:0] SEW_32   = 2'd2;
    localparam logic [1:0] SEW_RSVD = 2'd3;

    localparam logic [1:0] LMUL_1 = 2'd0;
    localparam logic [1:0] LMUL_2 = 2'd1;
    localparam logic [1:0] LMUL_4 = 2'd2;
    localparam logic [1:0] LMUL_8 = 2'd3;

    // Narrowest element width; sets elements per register as VLEN/8.
    localparam int ELEM_MIN_BITS = 8;

    function automatic logic [3:0] lmul_regs(input logic [1:0] lmul);
        logic [3:0] r;
        r = 4'd1;
        case (lmul)
            LMUL_1: r = 4'd1;
            LMUL_2: r = 4'd2;
            LMUL_4: r = 4'd4;
            LMUL_8: r = 4'd8;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vector_exec_sequencer_beat_calc.sv
// Combinational sizing for one vector instruction: beat count, legality
// and the number of elements written on beat k.
module vector_exec_sequencer_beat_calc
    import vector_exec_sequencer_pkg::*;
#(
    parameter int EPR_MAX = 16,
    parameter int AW      = 5
) (
    input  logic [1:0]    vsew,
    input  logic [1:0]    vlmul,
    input  logic [4:0]    vl,
    input  logic [AW-1:0] vs1_base,
    input  logic [AW-1:0] vs2_base,
    input  logic [AW-1:0] vd_base,
    input  logic [3:0]    k,
    output logic [3:0]    beats,
    output logic          illegal,
    output logic [4:0]    elems
);

    localparam int EPR_LOG2 = $clog2(EPR_MAX);

    logic [7:0]    epr;
    logic [2:0]    sh;
    logic [3:0]    regs;
    logic [7:0]    capacity;
    logic [4:0]    vl_eff;
    logic [7:0]    round_up;
    logic [7:0]    done_elems;
    logic [7:0]    remaining;
    logic [AW-1:0] align_mask;

    // epr is a power of two, so divides by it become shifts by sh.
    always_comb begin
        epr = 8'(EPR_MAX);
        sh  = 3'(EPR_LOG2);
        case (vsew)
            SEW_8: begin
                epr = 8'(EPR_MAX);
                sh  = 3'(EPR_LOG2);
            end
            SEW_16: begin
                epr = 8'(EPR_MAX / 2);
                sh  = 3'(EPR_LOG2 - 1);
            end
            SEW_32: begin
                epr = 8'(EPR_MAX / 4);
                sh  = 3'(EPR_LOG2 - 2);
            end
            default: begin
                epr = 8'(EPR_MAX / 8);
                sh  = 3'(EPR_LOG2 - 3);
            end
        endcase
    end

    assign regs       = lmul_regs(vlmul);
    assign capacity   = epr * {4'b0, regs};
    assign vl_eff     = ({3'b0, vl} < capacity) ? vl : 5'(capacity);
    assign round_up   = {3'b0, vl_eff} + epr - 8'd1;
    assign beats      = 4'(round_up >> sh);
    assign done_elems = {4'b0, k} << sh;
    assign remaining  = {3'b0, vl_eff} - done_elems;
    assign elems      = (remaining < epr) ? 5'(remaining) : 5'(epr);

    assign align_mask = AW'(regs - 4'd1);
    assign illegal    = (vsew == SEW_RSVD) ||
                        (|((vs1_base | vs2_base | vd_base) & align_mask));

endmodule

// File: rtl/vector_exec_sequencer.sv
// Steps one decoded vector instruction through its LMUL register group,
// one register per cycle, driving register-file addresses and PE controls.
module vector_exec_sequencer
    import vector_exec_sequencer_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int NREGS = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [$clog2(NREGS)-1:0]  vs1_base,
    input  logic [$clog2(NREGS)-1:0]  vs2_base,
    input  logic [$clog2(NREGS)-1:0]  vd_base,
    input  logic                      is_reduction,
    input  logic [4:0]                vl,
    input  logic [1:0]                vsew,
    input  logic [1:0]                vlmul,
    output logic [$clog2(NREGS)-1:0]  vs1_addr,
    output logic [$clog2(NREGS)-1:0]  vs2_addr,
    output logic [$clog2(NREGS)-1:0]  vd_addr,
    output logic [4:0]                elements_to_write,
    output logic                      write,
    output logic                      pe_ripple_inputs,
    output logic [1:0]                vsew_q,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    // state | meaning
    // IDLE  | ready for a new instruction; beat 0 is issued on acceptance
    // RUN   | beats 0..beats-1 on the outputs, one register per cycle
    // DONE  | done/error pulse on the outputs, beat outputs zero

    localparam int AW = $clog2(NREGS);

    seq_state_t    state_q, state_n;
    logic [3:0]    beat_q, beat_n;
    logic [AW-1:0] vs1_q, vs2_q, vd_q;
    logic          red_q;
    logic [4:0]    vl_q;
    logic [1:0]    vlmul_q;

    logic          is_idle;
    logic [AW-1:0] c_vs1, c_vs2, c_vd;
    logic          c_red;
    logic [4:0]    c_vl;
    logic [1:0]    c_vsew, c_vlmul;
    logic [3:0]    c_k;
    logic [3:0]    beats;
    logic          illegal;
    logic [4:0]    elems;

    logic          accept;
    logic [AW-1:0] b_vs1, b_vs2, b_vd;
    logic [4:0]    b_elems;
    logic [AW-1:0] vs1_n, vs2_n, vd_n;
    logic [4:0]    elems_n;
    logic          write_n, ripple_n, ready_n, busy_n, done_n, error_n;

    // While idle the sizing looks at the live decoder inputs so beat 0 can
    // be registered on the accepting edge; afterwards only latched values.
    assign is_idle = (state_q == IDLE);
    assign c_vs1   = is_idle ? vs1_base     : vs1_q;
    assign c_vs2   = is_idle ? vs2_base     : vs2_q;
    assign c_vd    = is_idle ? vd_base      : vd_q;
    assign c_red   = is_idle ? is_reduction : red_q;
    assign c_vl    = is_idle ? vl           : vl_q;
    assign c_vsew  = is_idle ? vsew         : vsew_q;
    assign c_vlmul = is_idle ? vlmul        : vlmul_q;
    assign c_k     = is_idle ? 4'd0         : beat_q;

    vector_exec_sequencer_beat_calc #(
        .EPR_MAX (VLEN / ELEM_MIN_BITS),
        .AW      (AW)
    ) u_beat_calc (
        .vsew     (c_vsew),
        .vlmul    (c_vlmul),
        .vl       (c_vl),
        .vs1_base (c_vs1),
        .vs2_base (c_vs2),
        .vd_base  (c_vd),
        .k        (c_k),
        .beats    (beats),
        .illegal  (illegal),
        .elems    (elems)
    );

    // A reduction folds its scalar through vd[0]: beat 0 seeds from vs1,
    // later beats read back the partial result.
    assign b_vs2   = c_vs2 + AW'(c_k);
    assign b_vs1   = c_red ? ((c_k == 4'd0) ? c_vs1 : c_vd) : (c_vs1 + AW'(c_k));
    assign b_vd    = c_red ? c_vd : (c_vd + AW'(c_k));
    assign b_elems = c_red ? 5'd1 : elems;

    always_comb begin
        state_n  = state_q;
        beat_n   = beat_q;
        accept   = 1'b0;
        vs1_n    = '0;
        vs2_n    = '0;
        vd_n     = '0;
        elems_n  = '0;
        write_n  = 1'b0;
        ripple_n = 1'b0;
        ready_n  = 1'b0;
        busy_n   = 1'b1;
        done_n   = 1'b0;
        error_n  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_n = 1'b1;
                busy_n  = 1'b0;
                if (instr_valid) begin
                    accept  = 1'b1;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                    if (illegal || beats == 4'd0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        error_n = illegal;
                    end else begin
                        state_n  = RUN;
                        beat_n   = 4'd1;
                        vs1_n    = b_vs1;
                        vs2_n    = b_vs2;
                        vd_n     = b_vd;
                        elems_n  = b_elems;
                        write_n  = 1'b1;
                        ripple_n = c_red;
                    end
                end
            end
            RUN: begin
                if (beat_q == beats) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    beat_n   = beat_q + 4'd1;
                    vs1_n    = b_vs1;
                    vs2_n    = b_vs2;
                    vd_n     = b_vd;
                    elems_n  = b_elems;
                    write_n  = 1'b1;
                    ripple_n = c_red;
                end
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            beat_q            <= '0;
            vs1_q             <= '0;
            vs2_q             <= '0;
            vd_q              <= '0;
            red_q             <= 1'b0;
            vl_q              <= '0;
            vlmul_q           <= '0;
            vsew_q            <= '0;
            vs1_addr          <= '0;
            vs2_addr          <= '0;
            vd_addr           <= '0;
            elements_to_write <= '0;
            write             <= 1'b0;
            pe_ripple_inputs  <= 1'b0;
            instr_ready       <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            state_q <= state_n;
            beat_q  <= beat_n;
            if (accept) begin
                vs1_q   <= vs1_base;
                vs2_q   <= vs2_base;
                vd_q    <= vd_base;
                red_q   <= is_reduction;
                vl_q    <= vl;
                vlmul_q <= vlmul;
                vsew_q  <= vsew;
            end
            vs1_addr          <= vs1_n;
            vs2_addr          <= vs2_n;
            vd_addr           <= vd_n;
            elements_to_write <= elems_n;
            write             <= write_n;
            pe_ripple_inputs  <= ripple_n;
            instr_ready       <= ready_n;
            busy              <= busy_n;
            done              <= done_n;
            error             <= error_n;
        end
    end

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Directed bench for vector_exec_sequencer: an instruction-level model
// predicts every cycle's outputs, plus literal checks on key beats.
module tb_vector_exec_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [4:0] vs1_base, vs2_base, vd_base;
    logic       is_reduction;
    logic [4:0] vl;
    logic [1:0] vsew, vlmul;
    logic [4:0] vs1_addr, vs2_addr, vd_addr;
    logic [4:0] elements_to_write;
    logic       write, pe_ripple_inputs, busy, done, error;
    logic [1:0] vsew_q;

    typedef struct {
        int vsew, vlmul, vl, vs1, vs2, vd;
        bit red;
    } instr_t;

    typedef struct {
        bit rdy, bsy, wr, rip, dn, er;
        int vs1, vs2, vd, el;
    } exp_t;

    exp_t exp_q[$];
    int   exp_vsew = 0;
    int   checks = 0;
    int   errors = 0;

    vector_exec_sequencer #(.VLEN(128), .NREGS(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .vs1_base          (vs1_base),
        .vs2_base          (vs2_base),
        .vd_base           (vd_base),
        .is_reduction      (is_reduction),
        .vl                (vl),
        .vsew              (vsew),
        .vlmul             (vlmul),
        .vs1_addr          (vs1_addr),
        .vs2_addr          (vs2_addr),
        .vd_addr           (vd_addr),
        .elements_to_write (elements_to_write),
        .write             (write),
        .pe_ripple_inputs  (pe_ripple_inputs),
        .vsew_q            (vsew_q),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // Expected cycle-by-cycle behaviour of one accepted instruction.
    task automatic model_push(input instr_t t);
        int epr, regs, vl_eff, beats, left;
        bit bad;
        exp_t e;
        epr    = 16 >> t.vsew;
        regs   = 1 << t.vlmul;
        bad    = (t.vsew == 3) || (t.vs1 % regs != 0) || (t.vs2 % regs != 0) || (t.vd % regs != 0);
        vl_eff = (t.vl < epr * regs) ? t.vl : epr * regs;
        beats  = (vl_eff + epr - 1) / epr;
        exp_vsew = t.vsew;
        if (!bad) begin
            for (int k = 0; k < beats; k++) begin
                e = '{rdy: 0, bsy: 1, wr: 1, rip: t.red, dn: 0, er: 0,
                      vs1: 0, vs2: (t.vs2 + k) % 32, vd: 0, el: 0};
                if (t.red) begin
                    e.vs1 = (k == 0) ? t.vs1 : t.vd;
                    e.vd  = t.vd;
                    e.el  = 1;
                end else begin
                    left  = vl_eff - k * epr;
                    e.vs1 = (t.vs1 + k) % 32;
                    e.vd  = (t.vd + k) % 32;
                    e.el  = (left < epr) ? left : epr;
                end
                exp_q.push_back(e);
            end
        end
        e = '{rdy: 0, bsy: 1, wr: 0, rip: 0, dn: 1, er: bad, vs1: 0, vs2: 0, vd: 0, el: 0};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{rdy: 1, bsy: 0, wr: 0, rip: 0, dn: 0, er: 0, vs1: 0, vs2: 0, vd: 0, el: 0};
        chk("instr_ready", instr_ready, e.rdy);
        chk("busy", busy, e.bsy);
        chk("write", write, e.wr);
        chk("pe_ripple_inputs", pe_ripple_inputs, e.rip);
        chk("done", done, e.dn);
        chk("error", error, e.er);
        chk("vs1_addr", vs1_addr, e.vs1);
        chk("vs2_addr", vs2_addr, e.vs2);
        chk("vd_addr", vd_addr, e.vd);
        chk("elements_to_write", elements_to_write, e.el);
        chk("vsew_q", vsew_q, exp_vsew);
    end

    // Presents an instruction and holds valid until the sequencer takes it.
    task automatic send(input instr_t t);
        int n;
        @(negedge clk);
        vsew         = 2'(t.vsew);
        vlmul        = 2'(t.vlmul);
        vl           = 5'(t.vl);
        vs1_base     = 5'(t.vs1);
        vs2_base     = 5'(t.vs2);
        vd_base      = 5'(t.vd);
        is_reduction = t.red;
        instr_valid  = 1'b1;
        n = 0;
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            errors++;
            $display("FAIL accept_timeout: got not-ready expected ready at %0t", $time);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        model_push(t);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0 at %0t", exp_q.size(), $time);
        end
        @(negedge clk);
    endtask

    task automatic at_cycle();
        @(negedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_vs1[4];
        int nbeats, last_el, last_vd;
        reset = 1'b1;
        instr_valid = 1'b0;
        vs1_base = '0; vs2_base = '0; vd_base = '0;
        is_reduction = 1'b0; vl = '0; vsew = '0; vlmul = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // Single-beat 32-bit op.
        send('{vsew: 2, vlmul: 0, vl: 4, vs1: 1, vs2: 2, vd: 3, red: 0});
        at_cycle();
        chk("t1_vs1", vs1_addr, 1);
        chk("t1_vs2", vs2_addr, 2);
        chk("t1_vd", vd_addr, 3);
        chk("t1_elems", elements_to_write, 4);
        chk("t1_write", write, 1);
        at_cycle();
        chk("t1_done", done, 1);
        at_cycle();
        chk("t1_ready", instr_ready, 1);

        // Two-beat 8-bit op with partial last register.
        send('{vsew: 0, vlmul: 1, vl: 20, vs1: 4, vs2: 6, vd: 8, red: 0});
        at_cycle();
        chk("t2_b0_vs1", vs1_addr, 4);
        chk("t2_b0_elems", elements_to_write, 16);
        at_cycle();
        chk("t2_b1_vs1", vs1_addr, 5);
        chk("t2_b1_vd", vd_addr, 9);
        chk("t2_b1_elems", elements_to_write, 4);
        at_cycle();
        chk("t2_done", done, 1);
        drain();

        // Chained reduction.
        exp_vs1 = '{0, 8, 8, 8};
        send('{vsew: 2, vlmul: 2, vl: 13, vs1: 0, vs2: 4, vd: 8, red: 1});
        for (int k = 0; k < 4; k++) begin
            at_cycle();
            chk("t3_vs1", vs1_addr, exp_vs1[k]);
            chk("t3_vs2", vs2_addr, 4 + k);
            chk("t3_vd", vd_addr, 8);
            chk("t3_ripple", pe_ripple_inputs, 1);
            chk("t3_elems", elements_to_write, 1);
        end
        at_cycle();
        chk("t3_done", done, 1);
        drain();

        // Misaligned destination group.
        send('{vsew: 0, vlmul: 1, vl: 5, vs1: 0, vs2: 0, vd: 3, red: 0});
        at_cycle();
        chk("t4_done", done, 1);
        chk("t4_error", error, 1);
        chk("t4_write", write, 0);
        at_cycle();
        chk("t4_ready", instr_ready, 1);
        drain();

        // vl=0 then full-group 31 elements.
        send('{vsew: 2, vlmul: 3, vl: 0, vs1: 0, vs2: 8, vd: 16, red: 0});
        at_cycle();
        chk("t5a_done", done, 1);
        chk("t5a_write", write, 0);
        chk("t5a_error", error, 0);
        send('{vsew: 2, vlmul: 3, vl: 31, vs1: 0, vs2: 8, vd: 16, red: 0});
        nbeats = 0; last_el = 0; last_vd = 0;
        for (int c = 0; c < 20; c++) begin
            at_cycle();
            if (write) begin
                nbeats++;
                last_el = elements_to_write;
                last_vd = vd_addr;
            end
            if (done) break;
        end
        chk("t5b_beats", nbeats, 8);
        chk("t5b_last_elems", last_el, 3);
        chk("t5b_last_vd", last_vd, 23);
        drain();

        // Back-to-back with valid held and inputs changing while busy.
        send('{vsew: 1, vlmul: 1, vl: 12, vs1: 2, vs2: 4, vd: 6, red: 0});
        send('{vsew: 2, vlmul: 0, vl: 3, vs1: 9, vs2: 10, vd: 11, red: 1});
        send('{vsew: 3, vlmul: 0, vl: 5, vs1: 1, vs2: 2, vd: 3, red: 0});
        send('{vsew: 0, vlmul: 0, vl: 20, vs1: 1, vs2: 2, vd: 3, red: 0});
        send('{vsew: 1, vlmul: 3, vl: 31, vs1: 24, vs2: 16, vd: 8, red: 1});
        drain();

        // Reset during beat 2 of a four-beat op.
        send('{vsew: 2, vlmul: 2, vl: 16, vs1: 0, vs2: 4, vd: 8, red: 0});
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        exp_vsew = 0;
        #1;
        chk("rst_write", write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", instr_ready, 1);
        chk("rst_vd", vd_addr, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        send('{vsew: 2, vlmul: 0, vl: 4, vs1: 1, vs2: 2, vd: 3, red: 0});
        at_cycle();
        chk("post_rst_vd", vd_addr, 3);
        chk("post_rst_write", write, 1);
        drain();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
